lsu_sync: RTL and testbench
===========================

# lsu_sync

Parametrised, handshaked load/store unit with a synchronous-read data RAM, aligned-access checking, readable MMIO registers and a synchronised switch input. It sits in the MEM stage of the forwarding pipeline in place of the combinational load/store path. It accepts one request at a time, returns exactly one response per accepted request, and lets the pipeline stall on `o_ready`.

## Interface
Parameters:
- `DMEM_WORDS`, 2048: data RAM depth in 32-bit words; power of two, 256..16384.
- `SW_SYNC_STAGES`, 2: flops on `i_io_sw`; must be 2 or 3.

Ports:
- `i_clk`  in  1  sole clock; all state updates on its rising edge.
- `i_reset`  in  1  reset; synchronous, active-low.
- `i_req`  in  1  request valid.
- `o_ready`  out  1  unit can accept a request this cycle.
- `i_lsu_wren`  in  1  1 = store, 0 = load.
- `i_lsu_addr`  in  32  byte address.
- `i_st_data`  in  32  store data, LSB-aligned.
- `i_lsu_size`  in  2  00 byte, 01 half, 10 word; 11 is treated as word.
- `i_lsu_unsigned`  in  1  zero-extend a sub-word load.
- `o_rsp_valid`  out  1  one-cycle response strobe.
- `o_ld_data`  out  32  load result, valid only with `o_rsp_valid`.
- `o_misaligned`  out  1  access fault, valid only with `o_rsp_valid`.
- `i_io_sw`  in  32  asynchronous switch inputs.
- `o_io_ledr`, `o_io_ledg`, `o_io_lcd`  out  32 each  MMIO output registers.
- `o_io_hex`  out  8×7 (packed `[7:0][6:0]`)  seven-segment digit registers.

## Operation
- **FSM states:** IDLE and RESP.
  - `o_ready` = (state == IDLE).
  - Accept = `i_req && o_ready`. Accept moves IDLE→RESP. RESP always returns to IDLE after one cycle.
- **Inputs:** all request fields are sampled only at the accept edge. `i_req` while not ready is ignored, not queued.
- **Regions:**
  - DMEM: `addr < DMEM_WORDS*4`.
  - MMIO: exact-match LEDR 0x1000_0000, LEDG 0x1000_1000, HEX0_3 0x1000_2000, HEX4_7 0x1000_3000, LCD 0x1000_4000, SW 0x1001_0000.
  - Everything else is unmapped.
- **Alignment:** half requires `addr[0]=0`; word requires `addr[1:0]=0`.
  - A misaligned request performs no write, returns `o_ld_data=0` and `o_misaligned=1`.
- **Byte enables:**
  - byte: `4'b0001<<addr[1:0]`.
  - half: `addr[1] ? 1100 : 0011`.
  - word: 1111.
  - Store data is replicated across lanes (byte ×4, half ×2).
- **DMEM store:** written at the accept edge using byte enables.
- **MMIO store:** byte enables apply to the target register.
  - HEX0_3 maps bits [6:0], [14:8], [22:16], [30:24] to digits 0..3 (HEX4_7 to digits 4..7). Bits 7/15/23/31 are dropped.
  - Stores to SW or to unmapped addresses are ignored.
- **Load data sources:**
  - DMEM: RAM word registered at the accept edge, then lane-selected and sign/zero-extended in RESP.
  - LEDR/LEDG/LCD: current register value.
  - HEX: `{1'b0,d3,1'b0,d2,1'b0,d1,1'b0,d0}` (respectively d7..d4).
  - SW: synchronised switch value.
  - Unmapped: 32'hDEAD_BEEF.
- **Store response:** `o_ld_data=0`, `o_misaligned=0` unless misaligned.
- **Switch path:** `i_io_sw` passes through the `SW_SYNC_STAGES` flop chain.

## Timing
- **Reset** (`i_reset=0` at an edge): state IDLE, `o_rsp_valid=0`, LEDR/LEDG/LCD=0, all HEX=0, sync chain=0. RAM contents are not cleared.
  - Reset asserted while in RESP aborts the response; no strobe is produced.
  - A request coincident with reset is dropped, and any store in it does not write.
- **Latency:** accept at edge N; `o_rsp_valid=1` during cycle N+1, then 0. Throughput is one request per 2 cycles.
- **Store visibility:** a store accepted at N is visible to a load accepted at N+2, the earliest possible.
- **Outputs:** MMIO outputs change at the accept edge of the store.
- **Switch latency:** a change on `i_io_sw` is visible to a SW load accepted `SW_SYNC_STAGES` edges later.
- **Idle outputs:** `o_ld_data` and `o_misaligned` are 0 whenever `o_rsp_valid=0`.

## Structure
- Package `lsu_pkg`: size enum (`SZ_BYTE`, `SZ_HALF`, `SZ_WORD`), the MMIO address localparams, `UNMAPPED_DATA` = 32'hDEAD_BEEF, and the state enum.
- Sub-module `dmem_sync`:
  - parameter `DEPTH`;
  - `$clog2(DEPTH)`-bit word index taken from `addr[idx+1:2]`;
  - 4-bit byte-enable write;
  - registered read (read-before-write on the same address);
  - no reset.

## Test plan
- **Reset outputs:** after reset, all outputs are 0 and `o_ready=1`. Apply `i_req` with `i_reset=0` → `o_rsp_valid` stays 0.
- **Word round-trip:** SW 0x8000_00F1 @0x10; then LB @0x10 → 0xFFFF_FFF1; LBU → 0x0000_00F1; LH @0x12 → 0xFFFF_8000; LW → 0x8000_00F1. Each response comes one cycle after accept.
- **Sub-word store merge:** SB 0xAB @0x21, then SH 0x1234 @0x22 over prior word 0 → LW @0x20 = 0x1234_AB00.
- **Misalignment:** LW @0x6 → `o_misaligned=1`, data 0. SH 0xFFFF @0x5 → later LW @0x4 is unchanged.
- **MMIO readback:** SW 0x7F3F_065B → HEX0_3 sets digits 5B, 06, 3F, 7F. Load HEX0_3 → 0x7F3F_065B. Load from 0x2000_0000 → 0xDEAD_BEEF.
- **Handshake and reset:**
  - Switch input 0xA5 → SW load accepted 1 edge later returns the old value; accepted 2 edges later returns 0xA5.
  - `i_req` held high → accepts exactly every other cycle.
  - Reset in RESP → no strobe.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types, MMIO address map and lane helpers for the synchronous load/store unit.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } lsu_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } lsu_state_e;

    typedef enum logic [2:0] {
        RG_DMEM,
        RG_LEDR,
        RG_LEDG,
        RG_HEX03,
        RG_HEX47,
        RG_LCD,
        RG_SW,
        RG_NONE
    } lsu_region_e;

    localparam logic [31:0] ADDR_LEDR   = 32'h1000_0000;
    localparam logic [31:0] ADDR_LEDG   = 32'h1000_1000;
    localparam logic [31:0] ADDR_HEX0_3 = 32'h1000_2000;
    localparam logic [31:0] ADDR_HEX4_7 = 32'h1000_3000;
    localparam logic [31:0] ADDR_LCD    = 32'h1000_4000;
    localparam logic [31:0] ADDR_SW     = 32'h1001_0000;

    localparam logic [31:0] UNMAPPED_DATA = 32'hDEAD_BEEF;

    // Size code 2'b11 falls into the default arms and behaves as a word.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] off);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = 4'b0001 << off;
            SZ_HALF: be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic mis;
        case (size)
            SZ_BYTE: mis = 1'b0;
            SZ_HALF: mis = off[0];
            default: mis = |off;
        endcase
        return mis;
    endfunction

    function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
        logic [31:0] rep;
        case (size)
            SZ_BYTE: rep = {4{data[7:0]}};
            SZ_HALF: rep = {2{data[15:0]}};
            default: rep = data;
        endcase
        return rep;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/lsu_sync_dmem.sv
// Data RAM: byte-enable write, registered read (old data on same-address write), no reset.
module dmem_sync #(
    parameter int DEPTH = 2048
) (
    input  logic        i_clk,
    input  logic        i_re,
    input  logic        i_we,
    input  logic [3:0]  i_be,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata
);
    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    logic [31:0]      rdata_q;
    logic [IDX_W-1:0] idx;
    logic             unused_addr_bits;

    assign idx              = i_addr[IDX_W+1:2];
    assign unused_addr_bits = ^{i_addr[31:IDX_W+2], i_addr[1:0]};
    assign o_rdata          = rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_re) rdata_q <= mem[idx];
        for (int b = 0; b < 4; b++) begin
            if (i_we && i_be[b]) mem[idx][b*8 +: 8] <= i_wdata[b*8 +: 8];
        end
    end

endmodule

// File: rtl/lsu_sync.sv
// Handshaked MEM-stage load/store unit: one request in flight, response strobe one cycle after accept.
module lsu_sync
    import lsu_pkg::*;
#(
    parameter int DMEM_WORDS     = 2048,
    parameter int SW_SYNC_STAGES = 2
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_req,
    output logic            o_ready,
    input  logic            i_lsu_wren,
    input  logic [31:0]     i_lsu_addr,
    input  logic [31:0]     i_st_data,
    input  logic [1:0]      i_lsu_size,
    input  logic            i_lsu_unsigned,
    output logic            o_rsp_valid,
    output logic [31:0]     o_ld_data,
    output logic            o_misaligned,
    input  logic [31:0]     i_io_sw,
    output logic [31:0]     o_io_ledr,
    output logic [31:0]     o_io_ledg,
    output logic [31:0]     o_io_lcd,
    output logic [7:0][6:0] o_io_hex
);
    localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS * 4);

    lsu_state_e  state_q, state_d;
    lsu_region_e region_q, region_d, region_in;
    logic [1:0]  size_q, size_d;
    logic [1:0]  off_q, off_d;
    logic        uns_q, uns_d;
    logic        wren_q, wren_d;
    logic        mis_q, mis_d;

    logic [31:0]     ledr_q, ledr_d;
    logic [31:0]     ledg_q, ledg_d;
    logic [31:0]     lcd_q, lcd_d;
    logic [7:0][6:0] hex_q, hex_d;
    logic [SW_SYNC_STAGES-1:0][31:0] sw_q, sw_d;

    logic        accept;
    logic        mis_in;
    logic        st_ok;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [31:0] ram_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] dmem_ld;
    logic [31:0] ld_mux;

    // A request coincident with reset is never accepted, so it cannot write anything.
    assign accept   = i_req && (state_q == ST_IDLE) && i_reset;
    assign mis_in   = is_misaligned(i_lsu_size, i_lsu_addr[1:0]);
    assign be_in    = byte_enable(i_lsu_size, i_lsu_addr[1:0]);
    assign wdata_in = replicate(i_lsu_size, i_st_data);
    assign st_ok    = accept && i_lsu_wren && !mis_in;

    always_comb begin
        region_in = RG_NONE;
        if (i_lsu_addr < DMEM_BYTES) begin
            region_in = RG_DMEM;
        end else begin
            case (i_lsu_addr)
                ADDR_LEDR:   region_in = RG_LEDR;
                ADDR_LEDG:   region_in = RG_LEDG;
                ADDR_HEX0_3: region_in = RG_HEX03;
                ADDR_HEX4_7: region_in = RG_HEX47;
                ADDR_LCD:    region_in = RG_LCD;
                ADDR_SW:     region_in = RG_SW;
                default:     region_in = RG_NONE;
            endcase
        end
    end

    dmem_sync #(
        .DEPTH (DMEM_WORDS)
    ) u_dmem (
        .i_clk   (i_clk),
        .i_re    (accept),
        .i_we    (st_ok && (region_in == RG_DMEM)),
        .i_be    (be_in),
        .i_addr  (i_lsu_addr),
        .i_wdata (wdata_in),
        .o_rdata (ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        region_d = region_q;
        size_d   = size_q;
        off_d    = off_q;
        uns_d    = uns_q;
        wren_d   = wren_q;
        mis_d    = mis_q;
        ledr_d   = ledr_q;
        ledg_d   = ledg_q;
        lcd_d    = lcd_q;
        hex_d    = hex_q;
        sw_d     = {sw_q[SW_SYNC_STAGES-2:0], i_io_sw};

        if (accept) begin
            state_d  = ST_RESP;
            region_d = region_in;
            size_d   = i_lsu_size;
            off_d    = i_lsu_addr[1:0];
            uns_d    = i_lsu_unsigned;
            wren_d   = i_lsu_wren;
            mis_d    = mis_in;
        end else if (state_q == ST_RESP) begin
            state_d = ST_IDLE;
        end

        // HEX lanes carry one 7-bit digit each; the lane MSB has no digit behind it.
        if (st_ok) begin
            case (region_in)
                RG_LEDR: ledr_d = merge_bytes(ledr_q, wdata_in, be_in);
                RG_LEDG: ledg_d = merge_bytes(ledg_q, wdata_in, be_in);
                RG_LCD:  lcd_d  = merge_bytes(lcd_q, wdata_in, be_in);
                RG_HEX03: begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_in[k]) hex_d[k] = wdata_in[k*8 +: 7];
                    end
                end
                RG_HEX47: begin
                    for (int k = 0; k < 4; k++) begin
                        if (be_in[k]) hex_d[k+4] = wdata_in[k*8 +: 7];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            ledr_q  <= '0;
            ledg_q  <= '0;
            lcd_q   <= '0;
            hex_q   <= '0;
            sw_q    <= '0;
        end else begin
            state_q <= state_d;
            ledr_q  <= ledr_d;
            ledg_q  <= ledg_d;
            lcd_q   <= lcd_d;
            hex_q   <= hex_d;
            sw_q    <= sw_d;
        end
        region_q <= region_d;
        size_q   <= size_d;
        off_q    <= off_d;
        uns_q    <= uns_d;
        wren_q   <= wren_d;
        mis_q    <= mis_d;
    end

    assign byte_sel = ram_rdata[{off_q, 3'b000} +: 8];
    assign half_sel = off_q[1] ? ram_rdata[31:16] : ram_rdata[15:0];

    always_comb begin
        case (size_q)
            SZ_BYTE: dmem_ld = uns_q ? {24'h0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: dmem_ld = uns_q ? {16'h0, half_sel} : {{16{half_sel[15]}}, half_sel};
            default: dmem_ld = ram_rdata;
        endcase

        case (region_q)
            RG_DMEM:  ld_mux = dmem_ld;
            RG_LEDR:  ld_mux = ledr_q;
            RG_LEDG:  ld_mux = ledg_q;
            RG_LCD:   ld_mux = lcd_q;
            RG_HEX03: ld_mux = {1'b0, hex_q[3], 1'b0, hex_q[2], 1'b0, hex_q[1], 1'b0, hex_q[0]};
            RG_HEX47: ld_mux = {1'b0, hex_q[7], 1'b0, hex_q[6], 1'b0, hex_q[5], 1'b0, hex_q[4]};
            RG_SW:    ld_mux = sw_q[SW_SYNC_STAGES-1];
            default:  ld_mux = UNMAPPED_DATA;
        endcase

        if (wren_q || mis_q) ld_mux = '0;
    end

    // Reset held during the response cycle suppresses the strobe.
    assign o_ready      = (state_q == ST_IDLE);
    assign o_rsp_valid  = (state_q == ST_RESP) && i_reset;
    assign o_ld_data    = o_rsp_valid ? ld_mux : '0;
    assign o_misaligned = o_rsp_valid && mis_q;
    assign o_io_ledr    = ledr_q;
    assign o_io_ledg    = ledg_q;
    assign o_io_lcd     = lcd_q;
    assign o_io_hex     = hex_q;

endmodule

// File: tb/tb_lsu_sync.sv
// Bench for lsu_sync: byte-level memory/MMIO model checked every cycle, plus literal directed cases.
module tb_lsu_sync;
    localparam int          WORDS  = 2048;
    localparam int          SYNC   = 2;
    localparam logic [31:0] DBYTES = WORDS * 4;
    localparam logic [31:0] A_LEDR = 32'h1000_0000;
    localparam logic [31:0] A_LEDG = 32'h1000_1000;
    localparam logic [31:0] A_HEX0 = 32'h1000_2000;
    localparam logic [31:0] A_HEX4 = 32'h1000_3000;
    localparam logic [31:0] A_LCD  = 32'h1000_4000;
    localparam logic [31:0] A_SW   = 32'h1001_0000;

    logic            clk = 1'b0;
    logic            i_reset = 1'b0;
    logic            i_req = 1'b0;
    logic            o_ready;
    logic            i_lsu_wren = 1'b0;
    logic [31:0]     i_lsu_addr = '0;
    logic [31:0]     i_st_data = '0;
    logic [1:0]      i_lsu_size = 2'b10;
    logic            i_lsu_unsigned = 1'b0;
    logic            o_rsp_valid;
    logic [31:0]     o_ld_data;
    logic            o_misaligned;
    logic [31:0]     i_io_sw = '0;
    logic [31:0]     o_io_ledr, o_io_ledg, o_io_lcd;
    logic [7:0][6:0] o_io_hex;

    lsu_sync #(.DMEM_WORDS(WORDS), .SW_SYNC_STAGES(SYNC)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_req(i_req), .o_ready(o_ready),
        .i_lsu_wren(i_lsu_wren), .i_lsu_addr(i_lsu_addr), .i_st_data(i_st_data),
        .i_lsu_size(i_lsu_size), .i_lsu_unsigned(i_lsu_unsigned),
        .o_rsp_valid(o_rsp_valid), .o_ld_data(o_ld_data), .o_misaligned(o_misaligned),
        .i_io_sw(i_io_sw), .o_io_ledr(o_io_ledr), .o_io_ledg(o_io_ledg),
        .o_io_lcd(o_io_lcd), .o_io_hex(o_io_hex)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte-addressed memory, plain MMIO registers, SW history.
    logic [7:0]  m_mem [int];
    logic [31:0] m_ledr, m_ledg, m_lcd;
    logic [6:0]  m_hex [8];
    logic [31:0] m_sw [SYNC];
    logic        m_pend = 1'b0;
    logic [31:0] e_data;
    logic        e_mis, e_known;
    bit          started = 0;

    task automatic model_access();
        int nb;
        logic [31:0] a, d, v;
        a  = i_lsu_addr;
        d  = i_st_data;
        nb = (i_lsu_size == 2'd0) ? 1 : (i_lsu_size == 2'd1) ? 2 : 4;
        e_mis   = (nb == 2 && a[0]) || (nb == 4 && a[1:0] != 2'b00);
        e_data  = 32'h0;
        e_known = 1'b1;
        if (e_mis) return;
        if (a < DBYTES) begin
            if (i_lsu_wren) begin
                for (int j = 0; j < nb; j++) m_mem[int'(a) + j] = d[8*j +: 8];
            end else begin
                v = 32'h0;
                for (int j = nb - 1; j >= 0; j--) begin
                    if (!m_mem.exists(int'(a) + j)) e_known = 1'b0;
                    else v = (v << 8) | 32'(m_mem[int'(a) + j]);
                end
                if (nb == 1 && !i_lsu_unsigned && v[7])  v = v | 32'hFFFF_FF00;
                if (nb == 2 && !i_lsu_unsigned && v[15]) v = v | 32'hFFFF_0000;
                e_data = v;
            end
        end else if (i_lsu_wren) begin
            for (int j = 0; j < nb; j++) begin
                case (a)
                    A_LEDR: m_ledr[8*j +: 8] = d[8*j +: 8];
                    A_LEDG: m_ledg[8*j +: 8] = d[8*j +: 8];
                    A_LCD:  m_lcd[8*j +: 8]  = d[8*j +: 8];
                    A_HEX0: m_hex[j]         = d[8*j +: 7];
                    A_HEX4: m_hex[4 + j]     = d[8*j +: 7];
                    default: ;
                endcase
            end
        end else begin
            case (a)
                A_LEDR:  e_data = m_ledr;
                A_LEDG:  e_data = m_ledg;
                A_LCD:   e_data = m_lcd;
                A_HEX0:  e_data = {1'b0, m_hex[3], 1'b0, m_hex[2], 1'b0, m_hex[1], 1'b0, m_hex[0]};
                A_HEX4:  e_data = {1'b0, m_hex[7], 1'b0, m_hex[6], 1'b0, m_hex[5], 1'b0, m_hex[4]};
                A_SW:    e_data = m_sw[SYNC-1];
                default: e_data = 32'hDEAD_BEEF;
            endcase
        end
    endtask

    always @(posedge clk) begin
        if (!i_reset) begin
            m_pend = 1'b0;
            m_ledr = '0;
            m_ledg = '0;
            m_lcd  = '0;
            for (int k = 0; k < 8; k++) m_hex[k] = '0;
            for (int k = 0; k < SYNC; k++) m_sw[k] = '0;
            started = 1;
        end else begin
            for (int k = SYNC - 1; k > 0; k--) m_sw[k] = m_sw[k-1];
            m_sw[0] = i_io_sw;
            if (m_pend) m_pend = 1'b0;
            else if (i_req) begin
                model_access();
                m_pend = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            logic        ev;
            logic [55:0] eh;
            ev = m_pend && i_reset;
            chk("rsp_valid", o_rsp_valid, ev);
            chk("ready", o_ready, !m_pend);
            if (ev) begin
                chk("misaligned", o_misaligned, e_mis);
                if (e_known) chk("ld_data", o_ld_data, e_data);
            end else begin
                chk("idle_ld_data", o_ld_data, 0);
                chk("idle_misaligned", o_misaligned, 0);
            end
            for (int k = 0; k < 8; k++) eh[k*7 +: 7] = m_hex[k];
            chk("ledr", o_io_ledr, m_ledr);
            chk("ledg", o_io_ledg, m_ledg);
            chk("lcd", o_io_lcd, m_lcd);
            chk("hex", o_io_hex, eh);
        end
    end

    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input logic uns,
                        output logic [31:0] rd, output logic mis);
        int n = 0;
        while (!o_ready && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_before_req", o_ready, 1);
        i_req = 1'b1; i_lsu_wren = wr; i_lsu_addr = a; i_st_data = d;
        i_lsu_size = sz; i_lsu_unsigned = uns;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("latency_one_cycle", o_rsp_valid, 1);
        rd  = o_ld_data;
        mis = o_misaligned;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] pick_addr();
        logic [31:0] mm [6];
        mm[0] = A_LEDR; mm[1] = A_LEDG; mm[2] = A_HEX0;
        mm[3] = A_HEX4; mm[4] = A_LCD;  mm[5] = A_SW;
        case ($urandom_range(0, 9))
            0, 1, 2, 3, 4, 5: return 32'($urandom_range(0, 255));
            6:       return DBYTES - 4 + 32'($urandom_range(0, 3));
            7:       return DBYTES + 32'($urandom_range(0, 7));
            8:       return mm[$urandom_range(0, 5)];
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          n;

        // Reset: a store presented during reset must be dropped.
        repeat (3) @(posedge clk);
        #1;
        i_req = 1'b1; i_lsu_wren = 1'b1; i_lsu_addr = A_LEDR; i_st_data = 32'h1234; i_lsu_size = 2'b10;
        @(posedge clk); #1;
        i_req = 1'b0;
        @(negedge clk);
        chk("reset_no_rsp", o_rsp_valid, 0);
        chk("reset_ledr", o_io_ledr, 0);
        chk("reset_ready", o_ready, 1);
        chk("reset_ld_data", o_ld_data, 0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        chk("post_reset_no_rsp", o_rsp_valid, 0);
        @(posedge clk); #1;

        xfer(1, 32'h10, 32'h8000_00F1, 2'b10, 0, rd, mis);
        chk("sw_rsp_data", rd, 0);
        xfer(0, 32'h10, 0, 2'b00, 0, rd, mis);  chk("lb", rd, 32'hFFFF_FFF1);
        xfer(0, 32'h10, 0, 2'b00, 1, rd, mis);  chk("lbu", rd, 32'h0000_00F1);
        xfer(0, 32'h12, 0, 2'b01, 0, rd, mis);  chk("lh", rd, 32'hFFFF_8000);
        xfer(0, 32'h10, 0, 2'b10, 0, rd, mis);  chk("lw", rd, 32'h8000_00F1);

        xfer(1, 32'h20, 32'h0, 2'b10, 0, rd, mis);
        xfer(1, 32'h21, 32'hAB, 2'b00, 0, rd, mis);
        xfer(1, 32'h22, 32'h1234, 2'b01, 0, rd, mis);
        xfer(0, 32'h20, 0, 2'b10, 0, rd, mis);  chk("merge_lw", rd, 32'h1234_AB00);

        xfer(0, 32'h6, 0, 2'b10, 0, rd, mis);
        chk("mis_lw_flag", mis, 1);
        chk("mis_lw_data", rd, 0);
        xfer(1, 32'h4, 32'hCAFE_F00D, 2'b10, 0, rd, mis);
        xfer(1, 32'h5, 32'hFFFF, 2'b01, 0, rd, mis);
        chk("mis_sh_flag", mis, 1);
        xfer(0, 32'h4, 0, 2'b10, 0, rd, mis);   chk("mis_sh_nowrite", rd, 32'hCAFE_F00D);

        xfer(1, A_HEX0, 32'h7F3F_065B, 2'b10, 0, rd, mis);
        chk("hex_digits", o_io_hex[3:0], 28'({7'h7F, 7'h3F, 7'h06, 7'h5B}));
        xfer(0, A_HEX0, 0, 2'b10, 0, rd, mis);  chk("hex03_read", rd, 32'h7F3F_065B);
        xfer(1, A_HEX4, 32'hFFFF_FFFF, 2'b10, 0, rd, mis);
        xfer(0, A_HEX4, 0, 2'b10, 0, rd, mis);  chk("hex47_drop_msb", rd, 32'h7F7F_7F7F);
        xfer(0, 32'h2000_0000, 0, 2'b10, 0, rd, mis); chk("unmapped", rd, 32'hDEAD_BEEF);
        xfer(1, DBYTES - 4, 32'h0BAD_F00D, 2'b10, 0, rd, mis);
        xfer(0, DBYTES - 4, 0, 2'b10, 0, rd, mis); chk("dmem_top_word", rd, 32'h0BAD_F00D);
        xfer(0, DBYTES, 0, 2'b10, 0, rd, mis);  chk("dmem_past_end", rd, 32'hDEAD_BEEF);

        // Switch synchroniser latency.
        i_io_sw = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        i_io_sw = 32'hA5;
        xfer(0, A_SW, 0, 2'b10, 0, rd, mis);    chk("sw_1edge_old", rd, 32'h0);
        i_io_sw = 32'h0;
        repeat (4) @(posedge clk);
        #1;
        i_io_sw = 32'hA5;
        repeat (SYNC - 1) begin @(posedge clk); #1; end
        xfer(0, A_SW, 0, 2'b10, 0, rd, mis);    chk("sw_2edge_new", rd, 32'hA5);

        // Request held high is accepted every other cycle.
        n = 0;
        i_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = 32'h10; i_lsu_size = 2'b10;
        repeat (8) begin
            @(negedge clk);
            if (o_rsp_valid) n++;
        end
        i_req = 1'b0;
        chk("held_req_strobes", n, 4);
        @(posedge clk); #1;

        // Reset during the response cycle.
        i_req = 1'b1; i_lsu_wren = 1'b0; i_lsu_addr = A_LEDG; i_lsu_size = 2'b10;
        @(posedge clk); #1;
        i_req = 1'b0; i_reset = 1'b0;
        @(negedge clk);
        chk("rst_in_resp_no_strobe", o_rsp_valid, 0);
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(negedge clk);
        chk("rst_in_resp_after", o_rsp_valid, 0);
        @(posedge clk); #1;

        for (int w = 0; w < 64; w++) xfer(1, 32'(w * 4), $urandom, 2'b10, 0, rd, mis);

        for (int c = 0; c < 1200; c++) begin
            i_req          = ($urandom_range(0, 3) != 0);
            i_lsu_wren     = 1'($urandom_range(0, 1));
            i_lsu_addr     = pick_addr();
            i_st_data      = $urandom;
            i_lsu_size     = 2'($urandom_range(0, 3));
            i_lsu_unsigned = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0) i_io_sw = $urandom;
            i_reset        = ($urandom_range(0, 79) != 0);
            @(posedge clk); #1;
        end
        i_reset = 1'b1;
        i_req   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
